// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: active-low segment
// patterns, anode codes and the packed layout of a display word.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_SEL [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct packed {
        logic [3:0]  dp_mask;
        logic [15:0] digits;
    } disp_t;

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational BCD-to-seven-segment encoder; values 10-15 show a dash.
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        for (int unsigned v = 0; v < 10; v++) begin
            if (value_i == 4'(v)) begin
                seg_o = SEG_DIGIT[v];
            end
        end
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller with anode guard window, leading-zero
// blanking and a load handshake that commits new data only at frame boundaries.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_mask_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending,
    output logic        commit,
    output logic        frame_tick
);

    localparam int unsigned PrescW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(REFRESH_DIV - 1);
    localparam logic [PrescW-1:0] GuardEnd = PrescW'(GUARD_CYC);

    logic [PrescW-1:0] presc_q, presc_d;
    logic [1:0]        idx_q, idx_d;
    disp_t             shadow_q, shadow_d;
    disp_t             display_q, display_d;
    logic              pending_q, pending_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              commit_q, commit_d;
    logic              frame_tick_q, frame_tick_d;

    logic       slot_end;
    logic       boundary;
    disp_t      incoming;
    logic [3:0] zero_nib;
    logic [3:0] blank_flag;
    logic [3:0] cur_nib;
    logic [6:0] enc_seg;

    assign slot_end = (presc_q == PrescMax);
    assign boundary = slot_end && (idx_q == 2'd3);
    assign incoming = '{dp_mask: dp_mask_in, digits: digits_in};

    // Sequencing and the load/commit handshake.
    always_comb begin
        presc_d      = slot_end ? '0 : presc_q + PrescW'(1);
        idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
        shadow_d     = load ? incoming : shadow_q;
        pending_d    = pending_q | load;
        display_d    = display_q;
        commit_d     = 1'b0;
        frame_tick_d = boundary;
        if (boundary) begin
            // A load landing on the boundary bypasses the shadow path.
            if (load) begin
                display_d = incoming;
                pending_d = 1'b0;
                commit_d  = 1'b1;
            end else if (pending_q) begin
                display_d = shadow_q;
                pending_d = 1'b0;
                commit_d  = 1'b1;
            end
        end
    end

    // Digit i blanks only when it and every digit above it are zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            zero_nib[i] = (display_q.digits[4*i +: 4] == 4'd0);
        end
        blank_flag[3] = blank_lz & zero_nib[3];
        blank_flag[2] = blank_flag[3] & zero_nib[2];
        blank_flag[1] = blank_flag[2] & zero_nib[1];
        blank_flag[0] = 1'b0;
    end

    assign cur_nib = display_q.digits[{idx_q, 2'b00} +: 4];

    seg7_digit_enc u_digit_enc (
        .value_i (cur_nib),
        .blank_i (blank_flag[idx_q]),
        .seg_o   (enc_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (presc_q >= GuardEnd) begin
            an_d  = AN_SEL[idx_q];
            seg_d = enc_seg;
            dp_d  = ~display_q.dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            commit_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            commit_q     <= commit_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign pending    = pending_q;
    assign commit     = commit_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller for the four-digit seven-segment score display on the cricket-game board. It owns the digit-select sequence: it divides the system clock down to a digit refresh rate, steps a 2-bit digit index through the four anodes, and drives the matching segment pattern and decimal point. It inserts an anode-off guard window at each digit change to suppress ghosting. Game logic updates the display through a load handshake, and new data takes effect only at a frame boundary so that a score never appears torn.

## Interface
- REFRESH_DIV, 100000, clock cycles per digit slot (minimum 4); 1 kHz digit rate at 100 MHz.
- GUARD_CYC, 16, cycles at the start of each slot with all anodes off (must satisfy 1 ≤ GUARD_CYC < REFRESH_DIV).
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe that captures digits_in and dp_mask_in.
- digits_in  in  16  four BCD nibbles; [3:0] is digit 0 (rightmost, an[0]) and [15:12] is digit 3.
- dp_mask_in  in  4  bit i = 1 lights the decimal point of digit i.
- blank_lz  in  1  level signal; 1 enables leading-zero blanking.
- an  out  4  anode selects, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- pending  out  1  captured data is waiting for a frame boundary.
- commit  out  1  one-cycle pulse when new data reaches the display register.
- frame_tick  out  1  one-cycle pulse at the end of each digit-3 slot.

## Operation
- Prescaler
  - presc counts 0 to REFRESH_DIV−1, then wraps.
  - slot_end is asserted when presc == REFRESH_DIV−1.
- Digit index
  - idx is 2 bits and advances on slot_end: 0→1→2→3→0.
  - Anode code: idx 0 → 4'b1110, 1 → 4'b1101, 2 → 4'b1011, 3 → 4'b0111.
- Guard window
  - While presc < GUARD_CYC: an = 4'b1111, seg = 7'h7F, dp = 1.
  - Otherwise the outputs drive the pattern for digit idx.
- Segment pattern
  - BCD values 0–9 map to the standard patterns (for example 0 → 7'b1000000 and 8 → 7'b0000000).
  - Nibble values 10–15 display a dash: seg = 7'b0111111.
- Leading-zero blanking, applied when blank_lz = 1
  - Digit i (i = 3, 2, 1) is blanked if its nibble and every higher nibble equal 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode asserted but drives seg = 7'h7F.
  - A blanked digit drives dp = ~dp_mask[i], so its decimal point still shows.
- Load handshake
  - On load: shadow ← {dp_mask_in, digits_in}; pending ← 1.
  - A later load before commit overwrites the shadow (last write wins).
- Frame boundary (slot_end while idx == 3)
  - If pending: display ← shadow, pending ← 0, commit pulses.
  - frame_tick pulses on every boundary.
  - If load coincides with the boundary, the incoming digits_in and dp_mask_in are committed directly. In that case pending ends at 0, commit pulses, and the shadow also takes the new data.
- blank_lz is sampled live; it is not latched through the handshake.

## Timing
- All outputs are registered.
- Pipeline: state in cycle k (presc, idx, display) appears on an, seg and dp in cycle k+1.
- commit and frame_tick are asserted in the cycle after the boundary edge, aligned with idx = 0 and presc = 0.
- pending rises in the cycle after load.
- Display latency: new data first appears on seg at the first non-guard cycle of the digit-0 slot after commit.
- Reset values
  - an = 4'b1111, seg = 7'h7F, dp = 1.
  - pending = 0, commit = 0, frame_tick = 0.
  - presc = 0, idx = 0, shadow = 0, display = 0.
- Reset asserted mid-slot returns all state to these values immediately, without waiting for a clock edge.
- After reset release, the first anode assertion (an = 4'b1110) occurs at cycle GUARD_CYC+1.
- Frame period is 4·REFRESH_DIV cycles.

## Structure
- Package seg7_pkg holds:
  - Segment-pattern constants SEG_BLANK, SEG_DASH and SEG_DIGIT[0:9].
  - Anode-code constants AN_OFF and AN_SEL[0:3].
- Sub-module seg7_digit_enc (combinational): inputs are a 4-bit value and a blank flag; output is seg[6:0].
- The leading-zero blank flags are computed in the top level.
- Register elements: prescaler, idx counter, shadow and display registers, pending flag, output registers.

## Test plan
Use REFRESH_DIV = 8 and GUARD_CYC = 2 throughout.
- Reset, then free-run → an follows 1111 until cycle 3, then 1110 for 6 cycles. Subsequent slots follow 1111,1111,1101×6, then 1011, then 0111. frame_tick pulses every 32 cycles.
- load with digits_in = 16'h0123 and dp_mask_in = 4'b0010 mid-frame → pending = 1 until the boundary, then commit pulses. Next frame: seg shows 3, 2, 1 and 0 on digits 0–3, with dp = 0 only during digit 1.
- Same load with blank_lz = 1 → digit 3 shows seg = 7'h7F with its anode still asserted; digits 2–0 display normally.
- Two loads in one frame (16'h1111, then 16'h2222) → a single commit, and the display shows 2222.
- load coinciding with a boundary cycle → commit in the next cycle, pending stays 0, and the new data is shown in that frame.
- Nibble value 4'hA on digit 2 → seg = 7'b0111111 during the digit-2 slot. Assert rst_n = 0 mid-slot → outputs return to their reset values without waiting for a clock edge.
